// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver and held-key tracker.
package ps2_pkg;

  typedef enum logic [1:0] {
    DEC_IDLE,
    DEC_EXT,
    DEC_BRK,
    DEC_EXT_BRK
  } dec_state_e;

  localparam logic [7:0] CODE_E0    = 8'hE0;
  localparam logic [7:0] CODE_F0    = 8'hF0;
  localparam logic [8:0] CODE_EMPTY = 9'h0F0;

  // Keyboard status/ack bytes that never represent a key.
  function automatic logic is_ignored(input logic [7:0] b);
    case (b)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: is_ignored = 1'b1;
      default:                                  is_ignored = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronises the raw lines, detects ps2_clk falling edges,
// shifts in an 11-bit frame, checks odd parity and stop bit, aborts stalled frames.
module ps2_rx_frame #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  input  logic       clr_i,
  output logic [7:0] byte_o,
  output logic       valid_o,
  output logic       err_o
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
  logic                   clk_prev_q;
  logic [3:0]             count_q, count_d;
  logic [8:0]             shift_q, shift_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic [7:0]             byte_q, byte_d;
  logic                   valid_q, valid_d, err_q, err_d;
  logic                   clk_s, dat_s, fall;

  assign clk_s = clk_sync_q[SYNC_STAGES-1];
  assign dat_s = dat_sync_q[SYNC_STAGES-1];
  assign fall  = clk_prev_q & ~clk_s;

  // Synchronisers reset to the idle-high line level so reset never fakes an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
      count_q    <= '0;
      shift_q    <= '0;
      tmo_q      <= '0;
      byte_q     <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_dat_i};
      clk_prev_q <= clk_s;
      count_q    <= count_d;
      shift_q    <= shift_d;
      tmo_q      <= tmo_d;
      byte_q     <= byte_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  // count 0 = idle, 1..9 = data and parity pending, 10 = stop bit pending.
  always_comb begin
    count_d = count_q;
    shift_d = shift_q;
    tmo_d   = tmo_q;
    byte_d  = byte_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (clr_i) begin
      count_d = '0;
      tmo_d   = '0;
    end else if (fall) begin
      tmo_d = '0;
      if (count_q == 4'd0) begin
        if (!dat_s) count_d = 4'd1;
      end else if (count_q < 4'd10) begin
        shift_d = {dat_s, shift_q[8:1]};
        count_d = count_q + 4'd1;
      end else begin
        count_d = '0;
        if (dat_s && (^shift_q)) begin
          valid_d = 1'b1;
          byte_d  = shift_q[7:0];
        end else begin
          err_d = 1'b1;
        end
      end
    end else if (count_q != 4'd0) begin
      if (tmo_q == TMO_LAST) begin
        err_d   = 1'b1;
        count_d = '0;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  assign byte_o  = byte_q;
  assign valid_o = valid_q;
  assign err_o   = err_q;

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard receiver with E0/F0 decoding and an N-slot held-key table.
// Define PS2_REPEAT_EN to report typematic repeats of held keys as events.
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int NUM_SLOTS   = 3,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ps2_clk,
  input  logic                   ps2_dat,
  input  logic                   clr,
  output logic [7:0]             scan_data,
  output logic                   scan_valid,
  output logic                   frame_err,
  output logic                   evt_valid,
  output logic                   evt_break,
  output logic                   evt_repeat,
  output logic [8:0]             evt_code,
  output logic [NUM_SLOTS-1:0]   key_on,
  output logic [9*NUM_SLOTS-1:0] key_code,
  output logic                   slot_ovf
);

  localparam int IW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  logic [7:0] rx_byte;
  logic       rx_valid, rx_err;

  ps2_rx_frame #(
    .SYNC_STAGES (SYNC_STAGES),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk_i (ps2_clk),
    .ps2_dat_i (ps2_dat),
    .clr_i     (clr),
    .byte_o    (rx_byte),
    .valid_o   (rx_valid),
    .err_o     (rx_err)
  );

  dec_state_e                  state_q, state_d;
  logic [NUM_SLOTS-1:0]        on_q, on_d;
  logic [NUM_SLOTS-1:0][8:0]   code_q, code_d;
  logic                        evt_valid_q, evt_valid_d, evt_break_q, evt_break_d;
  logic [8:0]                  evt_code_q, evt_code_d;
  logic                        slot_ovf_q, slot_ovf_d;
  logic                        do_make, do_break, hit, free_found;
  logic [8:0]                  ev_code;
  logic [IW-1:0]               hit_idx, free_idx;
`ifdef PS2_REPEAT_EN
  logic                        evt_repeat_q, evt_repeat_d;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= DEC_IDLE;
      on_q        <= '0;
      code_q      <= {NUM_SLOTS{CODE_EMPTY}};
      evt_valid_q <= 1'b0;
      evt_break_q <= 1'b0;
      evt_code_q  <= '0;
      slot_ovf_q  <= 1'b0;
`ifdef PS2_REPEAT_EN
      evt_repeat_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      on_q        <= on_d;
      code_q      <= code_d;
      evt_valid_q <= evt_valid_d;
      evt_break_q <= evt_break_d;
      evt_code_q  <= evt_code_d;
      slot_ovf_q  <= slot_ovf_d;
`ifdef PS2_REPEAT_EN
      evt_repeat_q <= evt_repeat_d;
`endif
    end
  end

  // Prefix decoder: turns each good byte into at most one make or break request.
  always_comb begin
    state_d  = state_q;
    do_make  = 1'b0;
    do_break = 1'b0;
    ev_code  = {1'b0, rx_byte};
    if (clr) begin
      state_d = DEC_IDLE;
    end else if (rx_valid) begin
      case (state_q)
        DEC_IDLE: begin
          if (rx_byte == CODE_E0)      state_d = DEC_EXT;
          else if (rx_byte == CODE_F0) state_d = DEC_BRK;
          else if (!is_ignored(rx_byte)) do_make = 1'b1;
        end
        DEC_EXT: begin
          if (rx_byte == CODE_F0) begin
            state_d = DEC_EXT_BRK;
          end else begin
            do_make = 1'b1;
            ev_code = {1'b1, rx_byte};
            state_d = DEC_IDLE;
          end
        end
        DEC_BRK: begin
          do_break = 1'b1;
          state_d  = DEC_IDLE;
        end
        DEC_EXT_BRK: begin
          do_break = 1'b1;
          ev_code  = {1'b1, rx_byte};
          state_d  = DEC_IDLE;
        end
        default: state_d = DEC_IDLE;
      endcase
    end
  end

  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (on_q[i] && (code_q[i] == ev_code)) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
      if (!on_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
    end
  end

  // Slot table update and event outputs; clr wins over any event in the same cycle.
  always_comb begin
    on_d        = on_q;
    code_d      = code_q;
    evt_valid_d = 1'b0;
    evt_break_d = 1'b0;
    evt_code_d  = evt_code_q;
    slot_ovf_d  = 1'b0;
`ifdef PS2_REPEAT_EN
    evt_repeat_d = 1'b0;
`endif
    if (clr) begin
      on_d   = '0;
      code_d = {NUM_SLOTS{CODE_EMPTY}};
    end else if (do_make) begin
      evt_code_d = ev_code;
      if (hit) begin
`ifdef PS2_REPEAT_EN
        evt_valid_d  = 1'b1;
        evt_repeat_d = 1'b1;
`endif
      end else if (free_found) begin
        evt_valid_d      = 1'b1;
        on_d[free_idx]   = 1'b1;
        code_d[free_idx] = ev_code;
      end else begin
        evt_valid_d = 1'b1;
        slot_ovf_d  = 1'b1;
      end
    end else if (do_break) begin
      evt_valid_d = 1'b1;
      evt_break_d = 1'b1;
      evt_code_d  = ev_code;
      if (hit) begin
        on_d[hit_idx]   = 1'b0;
        code_d[hit_idx] = CODE_EMPTY;
      end
    end
  end

  assign scan_data  = rx_byte;
  assign scan_valid = rx_valid;
  assign frame_err  = rx_err;
  assign evt_valid  = evt_valid_q;
  assign evt_break  = evt_break_q;
  assign evt_code   = evt_code_q;
  assign key_on     = on_q;
  assign key_code   = code_q;
  assign slot_ovf   = slot_ovf_q;
`ifdef PS2_REPEAT_EN
  assign evt_repeat = evt_repeat_q;
`else
  assign evt_repeat = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Self-checking bench for ps2_key_tracker: byte-level vector table plus hand sequences
// for frame errors, timeout, repeat, clr and mid-frame reset; events checked by scoreboard.
module tb_ps2_key_tracker;

  localparam int NS  = 3;
  localparam int TMO = 400;
  localparam logic [8:0] E = 9'h0F0;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            ps2Clk = 1'b1;
  logic            ps2Dat = 1'b1;
  logic            clr = 1'b0;
  logic [7:0]      scanData;
  logic            scanValid, frameErr, evtValid, evtBreak, evtRepeat, slotOvf;
  logic [8:0]      evtCode;
  logic [NS-1:0]   keyOn;
  logic [9*NS-1:0] keyCode;

  ps2_key_tracker #(
    .NUM_SLOTS   (NS),
    .SYNC_STAGES (2),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2Clk),
    .ps2_dat    (ps2Dat),
    .clr        (clr),
    .scan_data  (scanData),
    .scan_valid (scanValid),
    .frame_err  (frameErr),
    .evt_valid  (evtValid),
    .evt_break  (evtBreak),
    .evt_repeat (evtRepeat),
    .evt_code   (evtCode),
    .key_on     (keyOn),
    .key_code   (keyCode),
    .slot_ovf   (slotOvf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       brk;
    logic       rpt;
    logic [8:0] code;
    logic       ovf;
  } evt_t;

  typedef struct {
    logic [7:0]      b;
    logic            evt;
    logic            brk;
    logic [8:0]      code;
    logic            ovf;
    logic [NS-1:0]   keyOnExp;
    logic [9*NS-1:0] keyCodeExp;
  } vec_t;

  evt_t expQ[$];
  evt_t actE, expE;
  vec_t vecs[24];
  int   vecCount = 0;
  int   missCount = 0;
  int   svCount = 0;
  int   errCount = 0;

  // Event scoreboard: every evt_valid pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (rst) begin
      if (scanValid) svCount++;
      if (frameErr) errCount++;
      if (evtValid) begin
        vecCount++;
        actE = '{brk: evtBreak, rpt: evtRepeat, code: evtCode, ovf: slotOvf};
        if (expQ.size() == 0) begin
          missCount++;
          $display("[TB] FAIL unexpected_event got brk=%0b rpt=%0b code=%03h ovf=%0b, required none",
                   actE.brk, actE.rpt, actE.code, actE.ovf);
        end else begin
          expE = expQ.pop_front();
          if (actE !== expE) begin
            missCount++;
            $display("[TB] FAIL event got brk=%0b rpt=%0b code=%03h ovf=%0b, required brk=%0b rpt=%0b code=%03h ovf=%0b",
                     actE.brk, actE.rpt, actE.code, actE.ovf, expE.brk, expE.rpt, expE.code, expE.ovf);
          end
        end
      end else if (slotOvf) begin
        vecCount++;
        missCount++;
        $display("[TB] FAIL ovf_without_event got slot_ovf=1, required 0");
      end
    end
  end

  task automatic pushEvent(input logic brk, input logic rpt, input logic [8:0] code, input logic ovf);
    expQ.push_back('{brk: brk, rpt: rpt, code: code, ovf: ovf});
  endtask

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic [NS-1:0] onExp, input logic [9*NS-1:0] codeExp);
    checkVal({name, "_key_on"}, 32'(keyOn), 32'(onExp));
    checkVal({name, "_key_code"}, 32'(keyCode), 32'(codeExp));
  endtask

  task automatic psBit(input logic v);
    ps2Dat = v;
    repeat (4) @(negedge clk);
    ps2Clk = 1'b0;
    repeat (8) @(negedge clk);
    ps2Clk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic flipPar, input logic flipStop, input int nBits);
    logic [10:0] bits;
    bits = {~flipStop, (~^b) ^ flipPar, b, 1'b0};
    for (int i = 0; i < nBits; i++) psBit(bits[i]);
    ps2Dat = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic sendByte(input logic [7:0] b);
    applyStimulus(b, 1'b0, 1'b0, 11);
  endtask

  initial begin
    int errBase, svBase;
    logic seen;

    vecs[0]  = '{8'h75, 1, 0, 9'h075, 0, 3'b001, {E, E, 9'h075}};
    vecs[1]  = '{8'hF0, 0, 0, 9'h000, 0, 3'b001, {E, E, 9'h075}};
    vecs[2]  = '{8'h75, 1, 1, 9'h075, 0, 3'b000, {E, E, E}};
    vecs[3]  = '{8'hE0, 0, 0, 9'h000, 0, 3'b000, {E, E, E}};
    vecs[4]  = '{8'h6B, 1, 0, 9'h16B, 0, 3'b001, {E, E, 9'h16B}};
    vecs[5]  = '{8'hE0, 0, 0, 9'h000, 0, 3'b001, {E, E, 9'h16B}};
    vecs[6]  = '{8'hF0, 0, 0, 9'h000, 0, 3'b001, {E, E, 9'h16B}};
    vecs[7]  = '{8'h6B, 1, 1, 9'h16B, 0, 3'b000, {E, E, E}};
    vecs[8]  = '{8'h6B, 1, 0, 9'h06B, 0, 3'b001, {E, E, 9'h06B}};
    vecs[9]  = '{8'h1A, 1, 0, 9'h01A, 0, 3'b011, {E, 9'h01A, 9'h06B}};
    vecs[10] = '{8'h12, 1, 0, 9'h012, 0, 3'b111, {9'h012, 9'h01A, 9'h06B}};
    vecs[11] = '{8'h21, 1, 0, 9'h021, 1, 3'b111, {9'h012, 9'h01A, 9'h06B}};
    vecs[12] = '{8'hF0, 0, 0, 9'h000, 0, 3'b111, {9'h012, 9'h01A, 9'h06B}};
    vecs[13] = '{8'h1A, 1, 1, 9'h01A, 0, 3'b101, {9'h012, E, 9'h06B}};
    vecs[14] = '{8'h21, 1, 0, 9'h021, 0, 3'b111, {9'h012, 9'h021, 9'h06B}};
    vecs[15] = '{8'hAA, 0, 0, 9'h000, 0, 3'b111, {9'h012, 9'h021, 9'h06B}};
    vecs[16] = '{8'hF0, 0, 0, 9'h000, 0, 3'b111, {9'h012, 9'h021, 9'h06B}};
    vecs[17] = '{8'h12, 1, 1, 9'h012, 0, 3'b011, {E, 9'h021, 9'h06B}};
    vecs[18] = '{8'hF0, 0, 0, 9'h000, 0, 3'b011, {E, 9'h021, 9'h06B}};
    vecs[19] = '{8'h21, 1, 1, 9'h021, 0, 3'b001, {E, E, 9'h06B}};
    vecs[20] = '{8'hF0, 0, 0, 9'h000, 0, 3'b001, {E, E, 9'h06B}};
    vecs[21] = '{8'h6B, 1, 1, 9'h06B, 0, 3'b000, {E, E, E}};
    vecs[22] = '{8'hF0, 0, 0, 9'h000, 0, 3'b000, {E, E, E}};
    vecs[23] = '{8'h33, 1, 1, 9'h033, 0, 3'b000, {E, E, E}};

    repeat (3) @(negedge clk);
    checkVal("reset_pulses", {26'd0, scanValid, frameErr, evtValid, evtBreak, evtRepeat, slotOvf}, 32'd0);
    checkVal("reset_data", {15'd0, scanData, evtCode}, 32'd0);
    checkOutput("reset", '0, {E, E, E});
    rst = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 24; i++) begin
      if (vecs[i].evt) pushEvent(vecs[i].brk, 1'b0, vecs[i].code, vecs[i].ovf);
      sendByte(vecs[i].b);
      checkVal($sformatf("vec%0d_scan_data", i), 32'(scanData), 32'(vecs[i].b));
      checkOutput($sformatf("vec%0d", i), vecs[i].keyOnExp, vecs[i].keyCodeExp);
    end

    errBase = errCount; svBase = svCount;
    applyStimulus(8'h5A, 1'b1, 1'b0, 11);
    checkVal("parity_err_count", 32'(errCount - errBase), 32'd1);
    checkVal("parity_no_scan", 32'(svCount - svBase), 32'd0);
    errBase = errCount;
    applyStimulus(8'h5A, 1'b0, 1'b1, 11);
    checkVal("stop_err_count", 32'(errCount - errBase), 32'd1);
    checkVal("stop_no_scan", 32'(svCount - svBase), 32'd0);

    errBase = errCount;
    applyStimulus(8'h5A, 1'b0, 1'b0, 4);
    repeat (TMO / 2) @(negedge clk);
    checkVal("timeout_not_early", 32'(errCount - errBase), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      if (errCount != errBase) begin
        seen = 1'b1;
        break;
      end
    end
    checkVal("timeout_err", 32'(seen), 32'd1);
    checkVal("timeout_no_scan", 32'(svCount - svBase), 32'd0);
    pushEvent(1'b0, 1'b0, 9'h05A, 1'b0);
    sendByte(8'h5A);
    checkOutput("after_timeout", 3'b001, {E, E, 9'h05A});
    pushEvent(1'b1, 1'b0, 9'h05A, 1'b0);
    sendByte(8'hF0);
    sendByte(8'h5A);
    checkOutput("release_5a", 3'b000, {E, E, E});

    pushEvent(1'b0, 1'b0, 9'h072, 1'b0);
    sendByte(8'h72);
`ifdef PS2_REPEAT_EN
    pushEvent(1'b0, 1'b1, 9'h072, 1'b0);
`endif
    sendByte(8'h72);
    checkOutput("repeat_72", 3'b001, {E, E, 9'h072});
    pushEvent(1'b1, 1'b0, 9'h072, 1'b0);
    sendByte(8'hF0);
    sendByte(8'h72);

    pushEvent(1'b0, 1'b0, 9'h01C, 1'b0);
    sendByte(8'h1C);
    checkOutput("hold_1c", 3'b001, {E, E, 9'h01C});
    seen = 1'b0;
    fork
      sendByte(8'h74);
      begin
        for (int i = 0; i < 400; i++) begin
          @(negedge clk);
          if (scanValid) begin
            seen = 1'b1;
            break;
          end
        end
        if (seen) begin
          clr = 1'b1;
          @(negedge clk);
          clr = 1'b0;
          checkVal("clr_no_evt", 32'(evtValid), 32'd0);
        end
      end
    join
    checkVal("clr_scan_seen", 32'(seen), 32'd1);
    checkOutput("after_clr", 3'b000, {E, E, E});
    sendByte(8'hF0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (2) @(negedge clk);
    pushEvent(1'b0, 1'b0, 9'h01C, 1'b0);
    sendByte(8'h1C);
    checkOutput("clr_resets_decoder", 3'b001, {E, E, 9'h01C});

    applyStimulus(8'h29, 1'b0, 1'b0, 5);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkVal("midrst_pulses", {26'd0, scanValid, frameErr, evtValid, evtBreak, evtRepeat, slotOvf}, 32'd0);
    checkOutput("midrst", 3'b000, {E, E, E});
    rst = 1'b1;
    errBase = errCount;
    repeat (TMO + 20) @(negedge clk);
    checkVal("midrst_no_timeout", 32'(errCount - errBase), 32'd0);
    pushEvent(1'b0, 1'b0, 9'h029, 1'b0);
    sendByte(8'h29);
    checkOutput("after_midrst", 3'b001, {E, E, 9'h029});

    repeat (10) @(negedge clk);
    checkVal("events_outstanding", 32'(expQ.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
